// File: rtl/brick_ctrl_pkg.sv
// brick_ctrl_pkg: shared widths, key bit positions, brick/state encodings and
// position helpers for the active-brick sequencer.
// A position packs a 4-bit column above a 5-bit row: {x, y}.
package brick_ctrl_pkg;

    localparam int X_LEN          = 4;
    localparam int Y_LEN          = 5;
    localparam int POS_LEN        = X_LEN + Y_LEN;
    localparam int DIR_LEN        = 2;
    localparam int BRICK_LEN      = 3;
    localparam int KEY_PRESS_LEN  = 6;
    localparam int BCTL_STATE_LEN = 3;

    // Bit positions inside key_press_1plus.
    localparam int KEY_UP      = 0;
    localparam int KEY_DOWN    = 1;
    localparam int KEY_LEFT    = 2;
    localparam int KEY_RIGHT   = 3;
    localparam int KEY_SPACE   = 4;
    localparam int KEY_RIGHT_3 = 5;

    // Type 0 is reserved as "no brick" so an empty hold slot is distinguishable.
    localparam logic [BRICK_LEN-1:0] BRICK_I = 3'd1;

    typedef enum logic [BCTL_STATE_LEN-1:0] {
        BCTL_IDLE  = 3'd0,
        BCTL_CHECK = 3'd1,
        BCTL_PLACE = 3'd2,
        BCTL_CLEAR = 3'd3,
        BCTL_SPAWN = 3'd4,
        BCTL_OVER  = 3'd5
    } bctl_state_e;

    typedef enum logic [1:0] {
        TRY_MOVE  = 2'd0,
        TRY_DROP  = 2'd1,
        TRY_SPAWN = 2'd2
    } try_kind_e;

    function automatic logic [POS_LEN-1:0] make_pos(input logic [X_LEN-1:0] x,
                                                    input logic [Y_LEN-1:0] y);
        return {x, y};
    endfunction

    function automatic logic [X_LEN-1:0] pos_x(input logic [POS_LEN-1:0] p);
        return p[POS_LEN-1:Y_LEN];
    endfunction

    function automatic logic [Y_LEN-1:0] pos_y(input logic [POS_LEN-1:0] p);
        return p[Y_LEN-1:0];
    endfunction

endpackage

// File: rtl/brick_ctrl_gravity_timer.sv
// brick_ctrl_gravity_timer: free-running gravity step counter. tick is high in
// the cycle the count sits at TICKS-1; the count then wraps to 0.
// restart forces the count back to 0 and suppresses that cycle's tick.
module brick_ctrl_gravity_timer #(
    parameter int TICKS = 1500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;

    assign tick = en && !restart && (r_cnt == LAST);

    // Count while enabled, wrapping at TICKS-1; restart has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (restart)
            r_cnt <= '0;
        else if (en)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + ONE;
    end

endmodule

// File: rtl/brick_ctrl.sv
// brick_ctrl: active-brick game-play sequencer. Arbitrates key pulses and
// gravity into try-moves, validates them against the external collision
// check, places bricks, handshakes line clear and spawns the next brick.
// Optional hold slot (RIGHT_3 key) is built when BRICK_CTRL_HOLD_EN is defined.
//
// state | meaning
// IDLE  | waiting for a key or pending gravity step
// CHECK | try_* registers loaded, sampling is_collided
// PLACE | one-cycle place_pulse writes the brick into the board
// CLEAR | clr_req held until the line-clear unit reports clr_done
// SPAWN | load next_type at the spawn point, acknowledge the generator
// OVER  | spawn collided; frozen until reset
module brick_ctrl
    import brick_ctrl_pkg::*;
#(
    parameter int GRAVITY_TICKS = 1500,
    parameter int SPAWN_X       = 6,
    parameter int SPAWN_Y       = 18
) (
    input  logic                      main_clk,
    input  logic                      rst_1plus,
    input  logic [KEY_PRESS_LEN-1:0]  key_press_1plus,
    input  logic                      is_collided,
    input  logic [POS_LEN-1:0]        shadow_pos,
    input  logic [BRICK_LEN-1:0]      next_type,
    input  logic                      clr_done,
    output logic [POS_LEN-1:0]        cur_pos,
    output logic [DIR_LEN-1:0]        dir,
    output logic [BRICK_LEN-1:0]      brick_type,
    output logic [POS_LEN-1:0]        try_pos,
    output logic [DIR_LEN-1:0]        try_dir,
    output logic [BRICK_LEN-1:0]      try_type,
    output logic                      place_pulse,
    output logic                      clr_req,
    output logic                      next_ack,
    output logic                      game_over,
`ifdef BRICK_CTRL_HOLD_EN
    output logic [BRICK_LEN-1:0]      hold_type_o,
`endif
    output logic [BCTL_STATE_LEN-1:0] state_dbg
);

    localparam logic [POS_LEN-1:0] SPAWN_POS = make_pos(X_LEN'(SPAWN_X), Y_LEN'(SPAWN_Y));
    localparam logic [X_LEN-1:0]   X_ONE     = X_LEN'(1);
    localparam logic [Y_LEN-1:0]   Y_ONE     = Y_LEN'(1);
    localparam logic [DIR_LEN-1:0] DIR_ONE   = DIR_LEN'(1);

    bctl_state_e          r_state,      w_state_nxt;
    try_kind_e            r_kind,       w_kind_nxt;
    logic [POS_LEN-1:0]   r_cur_pos,    w_cur_pos_nxt;
    logic [DIR_LEN-1:0]   r_dir,        w_dir_nxt;
    logic [BRICK_LEN-1:0] r_brick_type, w_brick_type_nxt;
    logic [POS_LEN-1:0]   r_try_pos,    w_try_pos_nxt;
    logic [DIR_LEN-1:0]   r_try_dir,    w_try_dir_nxt;
    logic [BRICK_LEN-1:0] r_try_type,   w_try_type_nxt;
    logic                 r_grav_pend;
    logic                 w_grav_clr;
    logic                 w_restart;
    logic                 w_tick;
    logic                 w_grav_en;

`ifdef BRICK_CTRL_HOLD_EN
    logic [BRICK_LEN-1:0] r_hold_type, w_hold_type_nxt;
    logic                 r_hold_used, w_hold_used_nxt;
    assign hold_type_o = r_hold_type;
`else
    logic w_unused_right_3;
    assign w_unused_right_3 = key_press_1plus[KEY_RIGHT_3];
`endif

    assign w_grav_en = (r_state != BCTL_OVER);

    brick_ctrl_gravity_timer #(.TICKS(GRAVITY_TICKS)) u_gravity (
        .clk     (main_clk),
        .rst     (rst_1plus),
        .en      (w_grav_en),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Gravity request latch: a new tick always wins over a same-cycle service.
    always_ff @(posedge main_clk or posedge rst_1plus) begin
        if (rst_1plus)
            r_grav_pend <= 1'b0;
        else
            r_grav_pend <= w_tick | (r_grav_pend & ~w_grav_clr);
    end

    // State and brick registers.
    always_ff @(posedge main_clk or posedge rst_1plus) begin
        if (rst_1plus) begin
            r_state      <= BCTL_IDLE;
            r_kind       <= TRY_MOVE;
            r_cur_pos    <= SPAWN_POS;
            r_dir        <= '0;
            r_brick_type <= BRICK_I;
            r_try_pos    <= SPAWN_POS;
            r_try_dir    <= '0;
            r_try_type   <= BRICK_I;
`ifdef BRICK_CTRL_HOLD_EN
            r_hold_type  <= '0;
            r_hold_used  <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_kind       <= w_kind_nxt;
            r_cur_pos    <= w_cur_pos_nxt;
            r_dir        <= w_dir_nxt;
            r_brick_type <= w_brick_type_nxt;
            r_try_pos    <= w_try_pos_nxt;
            r_try_dir    <= w_try_dir_nxt;
            r_try_type   <= w_try_type_nxt;
`ifdef BRICK_CTRL_HOLD_EN
            r_hold_type  <= w_hold_type_nxt;
            r_hold_used  <= w_hold_used_nxt;
`endif
        end
    end

    // Next-state logic: request arbitration, collision outcome, handshakes.
    always_comb begin
        w_state_nxt      = r_state;
        w_kind_nxt       = r_kind;
        w_cur_pos_nxt    = r_cur_pos;
        w_dir_nxt        = r_dir;
        w_brick_type_nxt = r_brick_type;
        w_try_pos_nxt    = r_try_pos;
        w_try_dir_nxt    = r_try_dir;
        w_try_type_nxt   = r_try_type;
        w_grav_clr       = 1'b0;
        w_restart        = 1'b0;
`ifdef BRICK_CTRL_HOLD_EN
        w_hold_type_nxt  = r_hold_type;
        w_hold_used_nxt  = r_hold_used;
`endif
        case (r_state)
            BCTL_IDLE: begin
                if (key_press_1plus[KEY_SPACE]) begin
                    w_cur_pos_nxt = shadow_pos;
                    w_state_nxt   = BCTL_PLACE;
                end
`ifdef BRICK_CTRL_HOLD_EN
                else if (key_press_1plus[KEY_RIGHT_3] && !r_hold_used) begin
                    w_hold_used_nxt = 1'b1;
                    w_hold_type_nxt = r_brick_type;
                    if (r_hold_type == '0) begin
                        w_state_nxt = BCTL_SPAWN;
                    end else begin
                        w_try_pos_nxt  = SPAWN_POS;
                        w_try_dir_nxt  = '0;
                        w_try_type_nxt = r_hold_type;
                        w_kind_nxt     = TRY_SPAWN;
                        w_state_nxt    = BCTL_CHECK;
                    end
                end
`endif
                else if (r_grav_pend || key_press_1plus[KEY_DOWN]) begin
                    w_try_pos_nxt  = make_pos(pos_x(r_cur_pos), pos_y(r_cur_pos) - Y_ONE);
                    w_try_dir_nxt  = r_dir;
                    w_try_type_nxt = r_brick_type;
                    w_kind_nxt     = TRY_DROP;
                    w_grav_clr     = 1'b1;
                    w_state_nxt    = BCTL_CHECK;
                end else if (key_press_1plus[KEY_UP]) begin
                    w_try_pos_nxt  = r_cur_pos;
                    w_try_dir_nxt  = r_dir + DIR_ONE;
                    w_try_type_nxt = r_brick_type;
                    w_kind_nxt     = TRY_MOVE;
                    w_state_nxt    = BCTL_CHECK;
                end else if (key_press_1plus[KEY_LEFT]) begin
                    w_try_pos_nxt  = make_pos(pos_x(r_cur_pos) - X_ONE, pos_y(r_cur_pos));
                    w_try_dir_nxt  = r_dir;
                    w_try_type_nxt = r_brick_type;
                    w_kind_nxt     = TRY_MOVE;
                    w_state_nxt    = BCTL_CHECK;
                end else if (key_press_1plus[KEY_RIGHT]) begin
                    w_try_pos_nxt  = make_pos(pos_x(r_cur_pos) + X_ONE, pos_y(r_cur_pos));
                    w_try_dir_nxt  = r_dir;
                    w_try_type_nxt = r_brick_type;
                    w_kind_nxt     = TRY_MOVE;
                    w_state_nxt    = BCTL_CHECK;
                end
            end
            BCTL_CHECK: begin
                if (!is_collided) begin
                    w_cur_pos_nxt    = r_try_pos;
                    w_dir_nxt        = r_try_dir;
                    w_brick_type_nxt = r_try_type;
                    w_restart        = (r_kind == TRY_SPAWN);
                    w_state_nxt      = BCTL_IDLE;
                end else begin
                    case (r_kind)
                        TRY_MOVE: w_state_nxt = BCTL_IDLE;
                        TRY_DROP: w_state_nxt = BCTL_PLACE;
                        default:  w_state_nxt = BCTL_OVER;
                    endcase
                end
            end
            BCTL_PLACE: begin
`ifdef BRICK_CTRL_HOLD_EN
                w_hold_used_nxt = 1'b0;
`endif
                w_state_nxt = BCTL_CLEAR;
            end
            BCTL_CLEAR: begin
                if (clr_done)
                    w_state_nxt = BCTL_SPAWN;
            end
            BCTL_SPAWN: begin
                w_try_pos_nxt  = SPAWN_POS;
                w_try_dir_nxt  = '0;
                w_try_type_nxt = next_type;
                w_kind_nxt     = TRY_SPAWN;
                w_state_nxt    = BCTL_CHECK;
            end
            BCTL_OVER: begin
                w_state_nxt = BCTL_OVER;
            end
            default: begin
                w_state_nxt = BCTL_IDLE;
            end
        endcase
    end

    assign cur_pos     = r_cur_pos;
    assign dir         = r_dir;
    assign brick_type  = r_brick_type;
    assign try_pos     = r_try_pos;
    assign try_dir     = r_try_dir;
    assign try_type    = r_try_type;
    assign place_pulse = (r_state == BCTL_PLACE);
    assign clr_req     = (r_state == BCTL_CLEAR);
    assign next_ack    = (r_state == BCTL_SPAWN);
    assign game_over   = (r_state == BCTL_OVER);
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_brick_ctrl.sv
// tb_brick_ctrl: directed vectors for brick_ctrl. u_dut uses the default
// gravity period (never fires during the key tests); u_dut_g uses a 4-cycle
// gravity period with a permanently colliding board to walk the
// drop/place/clear/spawn/game-over path.
module tb_brick_ctrl;
    import brick_ctrl_pkg::*;

    logic                      main_clk;
    logic                      rst, g_rst;
    logic [KEY_PRESS_LEN-1:0]  key, g_key;
    logic                      collided, g_collided;
    logic [POS_LEN-1:0]        shadow, g_shadow;
    logic [BRICK_LEN-1:0]      nxt_type, g_nxt_type;
    logic                      clr_done, g_clr_done;
    logic [POS_LEN-1:0]        cur_pos, try_pos, g_cur_pos, g_try_pos;
    logic [DIR_LEN-1:0]        dir, try_dir, g_dir, g_try_dir;
    logic [BRICK_LEN-1:0]      btype, try_type, g_btype, g_try_type;
    logic                      place, clr_req, next_ack, game_over;
    logic                      g_place, g_clr_req, g_next_ack, g_game_over;
    logic [BCTL_STATE_LEN-1:0] state, g_state;
`ifdef BRICK_CTRL_HOLD_EN
    logic [BRICK_LEN-1:0]      hold_o, g_hold_o;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    brick_ctrl u_dut (
        .main_clk        (main_clk),
        .rst_1plus       (rst),
        .key_press_1plus (key),
        .is_collided     (collided),
        .shadow_pos      (shadow),
        .next_type       (nxt_type),
        .clr_done        (clr_done),
        .cur_pos         (cur_pos),
        .dir             (dir),
        .brick_type      (btype),
        .try_pos         (try_pos),
        .try_dir         (try_dir),
        .try_type        (try_type),
        .place_pulse     (place),
        .clr_req         (clr_req),
        .next_ack        (next_ack),
        .game_over       (game_over),
`ifdef BRICK_CTRL_HOLD_EN
        .hold_type_o     (hold_o),
`endif
        .state_dbg       (state)
    );

    brick_ctrl #(.GRAVITY_TICKS(4)) u_dut_g (
        .main_clk        (main_clk),
        .rst_1plus       (g_rst),
        .key_press_1plus (g_key),
        .is_collided     (g_collided),
        .shadow_pos      (g_shadow),
        .next_type       (g_nxt_type),
        .clr_done        (g_clr_done),
        .cur_pos         (g_cur_pos),
        .dir             (g_dir),
        .brick_type      (g_btype),
        .try_pos         (g_try_pos),
        .try_dir         (g_try_dir),
        .try_type        (g_try_type),
        .place_pulse     (g_place),
        .clr_req         (g_clr_req),
        .next_ack        (g_next_ack),
        .game_over       (g_game_over),
`ifdef BRICK_CTRL_HOLD_EN
        .hold_type_o     (g_hold_o),
`endif
        .state_dbg       (g_state)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge main_clk);
    endtask

    function automatic logic [KEY_PRESS_LEN-1:0] kbit(input int b);
        logic [KEY_PRESS_LEN-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic press(input logic [KEY_PRESS_LEN-1:0] k);
        key = k;
        step();
        key = '0;
    endtask

    initial begin
        rst = 1'b1;  g_rst = 1'b1;
        key = '0;    g_key = '0;
        collided = 1'b0; g_collided = 1'b1;
        shadow = make_pos(4'd6, 5'd0); g_shadow = make_pos(4'd6, 5'd0);
        nxt_type = 3'd3; g_nxt_type = 3'd5;
        clr_done = 1'b0; g_clr_done = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        chk("rst_state",    32'(state),     32'd0);
        chk("rst_cur_pos",  32'(cur_pos),   32'(make_pos(4'd6, 5'd18)));
        chk("rst_try_pos",  32'(try_pos),   32'(make_pos(4'd6, 5'd18)));
        chk("rst_dir",      32'(dir),       32'd0);
        chk("rst_type",     32'(btype),     32'd1);
        chk("rst_try_type", 32'(try_type),  32'd1);
        chk("rst_outs",     {28'd0, place, clr_req, next_ack, game_over}, 32'd0);

        clr_done = 1'b1;
        step();
        clr_done = 1'b0;
        chk("clr_done_idle_ignored", 32'(state), 32'd0);

        press(kbit(KEY_LEFT));
        chk("left_try_pos", 32'(try_pos), 32'(make_pos(4'd5, 5'd18)));
        chk("left_state_chk", 32'(state), 32'd1);
        chk("left_cur_hold", 32'(cur_pos), 32'(make_pos(4'd6, 5'd18)));
        step();
        chk("left_cur_pos", 32'(cur_pos), 32'(make_pos(4'd5, 5'd18)));
        chk("left_state_idle", 32'(state), 32'd0);

        press(kbit(KEY_DOWN));
        chk("down_try_pos", 32'(try_pos), 32'(make_pos(4'd5, 5'd17)));
        step();
        chk("down_cur_pos", 32'(cur_pos), 32'(make_pos(4'd5, 5'd17)));

        for (int i = 1; i <= 4; i++) begin
            press(kbit(KEY_UP));
            step();
            chk($sformatf("up_dir_%0d", i), 32'(dir), 32'(i % 4));
        end

        collided = 1'b1;
        press(kbit(KEY_RIGHT));
        chk("right_try_pos", 32'(try_pos), 32'(make_pos(4'd6, 5'd17)));
        chk("right_no_place0", 32'(place), 32'd0);
        step();
        collided = 1'b0;
        chk("right_blocked_cur", 32'(cur_pos), 32'(make_pos(4'd5, 5'd17)));
        chk("right_no_place1", 32'(place), 32'd0);
        chk("right_state_idle", 32'(state), 32'd0);

        press(kbit(KEY_SPACE) | kbit(KEY_LEFT));
        chk("space_cur_pos", 32'(cur_pos), 32'(make_pos(4'd6, 5'd0)));
        chk("space_place", 32'(place), 32'd1);
        chk("space_state", 32'(state), 32'd2);
        chk("space_left_dropped", 32'(try_pos), 32'(make_pos(4'd6, 5'd17)));
        step();
        chk("place_one_cycle", 32'(place), 32'd0);
        chk("clear_req_on", 32'(clr_req), 32'd1);
        repeat (5) step();
        chk("clear_req_held", 32'(clr_req), 32'd1);
        chk("clear_state_held", 32'(state), 32'd3);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_clr_req", 32'(clr_req), 32'd0);
        chk("async_rst_cur_pos", 32'(cur_pos), 32'(make_pos(4'd6, 5'd18)));
        chk("async_rst_place", 32'(place), 32'd0);
        step();
        rst = 1'b0;

        // Gravity path: ticks every 4 cycles, board always collides.
        g_rst = 1'b0;
        repeat (4) step();
        chk("grav_idle_before", 32'(g_state), 32'd0);
        step();
        chk("grav_drop_check", 32'(g_state), 32'd1);
        chk("grav_try_pos", 32'(g_try_pos), 32'(make_pos(4'd6, 5'd17)));
        step();
        chk("grav_place", 32'(g_place), 32'd1);
        chk("grav_cur_kept", 32'(g_cur_pos), 32'(make_pos(4'd6, 5'd18)));
        step();
        chk("grav_clr_req", 32'(g_clr_req), 32'd1);
        chk("grav_place_off", 32'(g_place), 32'd0);
        repeat (5) step();
        chk("grav_clr_wait", 32'(g_clr_req), 32'd1);
        chk("grav_no_ack_yet", 32'(g_next_ack), 32'd0);
        g_clr_done = 1'b1;
        step();
        g_clr_done = 1'b0;
        chk("grav_next_ack", 32'(g_next_ack), 32'd1);
        chk("grav_spawn_state", 32'(g_state), 32'd4);
        chk("grav_clr_drop", 32'(g_clr_req), 32'd0);
        step();
        chk("grav_ack_once", 32'(g_next_ack), 32'd0);
        chk("grav_spawn_try_type", 32'(g_try_type), 32'd5);
        chk("grav_spawn_try_pos", 32'(g_try_pos), 32'(make_pos(4'd6, 5'd18)));
        step();
        chk("over_game_over", 32'(g_game_over), 32'd1);
        chk("over_state", 32'(g_state), 32'd5);
        g_collided = 1'b0;
        g_key = kbit(KEY_LEFT) | kbit(KEY_SPACE);
        step();
        g_key = '0;
        g_clr_done = 1'b1;
        repeat (3) step();
        g_clr_done = 1'b0;
        chk("over_sticky_state", 32'(g_state), 32'd5);
        chk("over_sticky_flag", 32'(g_game_over), 32'd1);
        chk("over_cur_pos", 32'(g_cur_pos), 32'(make_pos(4'd6, 5'd18)));
        chk("over_type", 32'(g_btype), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
